seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Downstream display stage for the synchronous 4-bit counter chain. It takes four cascaded counter nibbles (QA..QD per stage) plus the top stage's ripple-carry, and time-multiplexes them onto a 4-digit common-anode seven-segment display. It captures a coherent frame snapshot, shows hex digits with optional leading-zero blanking, inserts anode dead-time against ghosting, and keeps a sticky overflow flag shown on the top digit's decimal point.

## Interface
Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range 4..2^20.
- DEAD, 4: cycles at the start of each slot with all anodes off; legal range 0..SCAN_DIV-1.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- i_bcd  in  16  counter nibbles; [3:0] = digit 0 (least significant), [15:12] = digit 3.
- i_rco  in  1  ripple-carry of the top counter stage.
- i_hold  in  1  1 = freeze the snapshot (display keeps its last frame).
- i_lzb  in  1  1 = leading-zero blanking enabled.
- i_ovf_clr  in  1  synchronous clear of the overflow flag.
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- o_dp  out  1  decimal point, active-low.
- o_an  out  4  digit anodes, active-low; bit k = digit k.
- o_ovf  out  1  sticky overflow flag.

## Operation
- Prescaler p counts 0..SCAN_DIV-1 and wraps. The slot tick is the edge where p == SCAN_DIV-1.
- The 2-bit slot index idx advances on each tick, wrapping 3→0. idx resets to 3, so the first tick selects digit 0.
- Snapshot snap[15:0] loads i_bcd on a tick where idx wraps to 0 and i_hold = 0. The frame never tears mid-scan. When i_hold = 1, snap is unchanged.
- Digit value: n = snap[4*idx+3 : 4*idx]. Decode as hex 0-F in standard patterns (0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110).
- Leading-zero blanking: with i_lzb = 1, digit k (k ≥ 1) shows o_seg = 7'h7F when snap nibbles k..3 are all zero. Digit 0 is never blanked.
- Overflow detect: a rising edge of i_rco (registered previous value) sets ovf. If i_ovf_clr and the rising edge occur in the same cycle, set wins.
- Decimal point: o_dp = ~ovf while idx == 3, else 1.
- Anodes: o_an = ~(1 << idx) when p ≥ DEAD, else 4'b1111. With DEAD = 0 the anodes are never all off after the first tick.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset values: p = 0, idx = 3, snap = 0, ovf = 0, o_an = 4'b1111, o_seg = 7'h7F, o_dp = 1, o_ovf = 0, rco_q = 0.
- From reset to the first tick, o_an stays 4'b1111. This is a blank warm-up of SCAN_DIV cycles.
- On the tick edge, idx, snap (if loading), o_seg and o_dp all update together. o_seg reflects the new idx and the new snapshot on that same edge.
- o_an goes low for the new digit DEAD cycles after the tick edge. It returns to 4'b1111 on the next tick edge, unless DEAD = 0.
- Full frame period = 4·SCAN_DIV cycles. Input-to-display latency is at most 4·SCAN_DIV + 1 cycles.
- o_ovf updates one cycle after the i_rco rising edge is sampled. The clear takes effect on the next edge.
- Asserting rst mid-frame forces the reset values immediately, asynchronously. The scan restarts with the warm-up.
- i_hold and i_lzb are sampled only at tick edges. Toggling them between ticks has no effect until the next tick.

## Structure
- Package seg7_pkg: 4-digit count constant, hex→segment pattern constants (SEG_0..SEG_F, SEG_BLANK = 7'h7F), anode-off constant.
- Sub-module hex_to_seg7: combinational 4-bit → 7-bit active-low decoder, instantiated once on the selected nibble.
- Top-level: prescaler, idx FSM (four states DIG0..DIG3, cyclic), snapshot register, blanking logic, overflow edge detector.

## Test plan
Each scenario runs with SCAN_DIV = 8 and DEAD = 2.
- Reset, then idle 40 cycles with i_bcd = 16'h1234 → o_an = 4'b1111 for cycles 0-9; at cycle 10, o_an = 4'b1110 with o_seg = SEG_4; digits 3, 2, 1 follow at 8-cycle steps.
- i_bcd = 16'h0050, i_lzb = 1 → digits 3 and 2 show 7'h7F, digit 1 shows SEG_5, digit 0 shows SEG_0. With i_lzb = 0, digits 3 and 2 show SEG_0.
- Change i_bcd from 16'h1111 to 16'h2222 while idx = 1 → digits 2 and 3 still show 1 in that frame; the next frame shows all 2.
- i_hold = 1, then change i_bcd → the display is unchanged for 3 frames. Release i_hold → the new value appears at the next digit-0 tick.
- Pulse i_rco for 1 cycle → o_ovf = 1 one cycle later, and o_dp = 0 only while digit 3 is active. Assert i_ovf_clr together with a new i_rco edge → o_ovf stays 1. i_ovf_clr alone → o_ovf = 0.
- Assert rst for 3 cycles mid-scan while digit 2 is active → o_an = 4'b1111 and o_seg = 7'h7F immediately; o_ovf = 0; digit 0 is shown first after SCAN_DIV + DEAD cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared digit count, active-low segment patterns and scan state type
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_t;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational 4-bit to active-low {g,f,e,d,c,b,a} decoder
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed hex display with frame snapshot, zero blanking, dead-time and sticky overflow
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEAD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_bcd,
  input  logic                    i_rco,
  input  logic                    i_hold,
  input  logic                    i_lzb,
  input  logic                    i_ovf_clr,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_ovf
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] p, p_n;
  dig_t idx, idx_n;
  logic [4*NUM_DIGITS-1:0] snap, snap_n;
  logic live, live_n, ovf, ovf_n, rco_q, tick, blank, dp_n;
  logic [3:0] nib;
  logic [6:0] dec, seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
      idx <= DIG3;
      snap <= '0;
      live <= 1'b0;
      ovf <= 1'b0;
      rco_q <= 1'b0;
    end else begin
      p <= p_n;
      idx <= idx_n;
      snap <= snap_n;
      live <= live_n;
      ovf <= ovf_n;
      rco_q <= i_rco;
    end
  end
  // live stays low through the warm-up slot so idx=DIG3 is never lit before the first tick
  always_comb begin
    tick = p == PW'(SCAN_DIV - 1);
    p_n = tick ? '0 : p + 1'b1;
    idx_n = tick ? dig_t'(idx + 2'd1) : idx;
    snap_n = (tick && idx == DIG3 && !i_hold) ? i_bcd : snap;
    live_n = live | tick;
    ovf_n = (i_rco & ~rco_q) | (ovf & ~i_ovf_clr);
  end
  hex_to_seg7 u_dec (.hex(nib), .seg(dec));
  always_comb begin
    nib = snap_n[{idx_n, 2'b00} +: 4];
    blank = i_lzb && idx_n != DIG0 && (snap_n >> {idx_n, 2'b00}) == '0;
    seg_n = tick ? (blank ? SEG_BLANK : dec) : o_seg;
    an_n = (live_n && p_n >= PW'(DEAD)) ? ~(NUM_DIGITS'(1) << idx_n) : AN_OFF;
    dp_n = ~(live_n && idx_n == DIG3 && ovf_n);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_seg <= SEG_BLANK;
      o_an <= AN_OFF;
      o_dp <= 1'b1;
    end else begin
      o_seg <= seg_n;
      o_an <= an_n;
      o_dp <= dp_n;
    end
  end
  assign o_ovf = ovf;
endmodule
